// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared encodings for the counter sequencer.
//   - CTRL_*  : control codes driven to the universal counter
//   - state_t : sequencer FSM states
//   - ST_*    : job completion status codes
package counter_seq_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_UP   = 2'b01;
  localparam logic [1:0] CTRL_DOWN = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/counter_seq_wdog.sv
// counter_seq_wdog: RUN-cycle watchdog for the counter sequencer.
// Only instantiated when COUNTER_SEQ_WDOG_EN is defined.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the count (job accepted, entering LOAD)
//   enable    : count this cycle (sequencer in RUN)
//   expired   : this RUN cycle is the WDOG_MAX-th one of the job
module counter_seq_wdog
  import counter_seq_pkg::*;
#(
  parameter int WDOG_MAX = 1024,
  parameter int WDOG_W   = $clog2(WDOG_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_MAX - 1);
  localparam logic [WDOG_W-1:0] CAP  = WDOG_W'(WDOG_MAX);

  // cnt holds the number of RUN cycles already completed in this job
  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CAP)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flag during the cycle that would complete WDOG_MAX RUN cycles so the
  // FSM leaves RUN exactly after that many cycles.
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for an N-bit universal
// counter. Accepts one job (start, target, direction) over valid/ready,
// loads the counter, counts to the target and reports status + final count.
// Optional feature: define COUNTER_SEQ_WDOG_EN to add a RUN-cycle watchdog
// that ends a job with status ST_TIMEOUT after WDOG_MAX RUN cycles.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_valid/ready   : job handshake; cmd_dir/start/target job fields
//   abort             : terminate the current job
//   ctr_control       : counter control (hold/up/down/load)
//   ctr_parallel_in   : counter parallel-load value (latched start)
//   ctr_count         : counter output
//   busy, done        : job in progress / one-cycle completion pulse
//   status            : completion code, held until the next done
//   final_count       : counter value captured on entry to DONE, held
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int N        = 16,
  parameter int WDOG_MAX = 1024,
  parameter int WDOG_W   = $clog2(WDOG_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_target,
  input  logic         abort,
  output logic [1:0]   ctr_control,
  output logic [N-1:0] ctr_parallel_in,
  input  logic [N-1:0] ctr_count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   status,
  output logic [N-1:0] final_count
);

  state_t       state, state_next;
  logic         dir_q;
  logic [N-1:0] target_q;
  logic         accept;
  logic         match;
  logic         wdog_expired;
  logic         end_job;
  logic [1:0]   end_status;

  assign accept = (state == S_IDLE) && cmd_valid;
  assign match  = (ctr_count == target_q);

`ifdef COUNTER_SEQ_WDOG_EN
  counter_seq_wdog #(
    .WDOG_MAX (WDOG_MAX),
    .WDOG_W   (WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state == S_RUN),
    .expired (wdog_expired)
  );
`else
  // No watchdog in this build; the expression is false for every legal
  // WDOG_MAX and keeps the parameter list identical across builds.
  assign wdog_expired = (WDOG_W == 0);
`endif

  always_comb begin
    state_next  = state;
    ctr_control = CTRL_HOLD;
    end_job     = 1'b0;
    end_status  = ST_OK;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_next = S_LOAD;
      end
      S_LOAD: begin
        ctr_control = CTRL_LOAD;
        if (abort) begin
          state_next = S_DONE;
          end_job    = 1'b1;
          end_status = ST_ABORT;
        end else begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Priority: abort, then match, then watchdog expiry.
        if (abort) begin
          state_next = S_DONE;
          end_job    = 1'b1;
          end_status = ST_ABORT;
        end else if (match) begin
          state_next = S_DONE;
          end_job    = 1'b1;
          end_status = ST_OK;
        end else begin
          ctr_control = dir_q ? CTRL_DOWN : CTRL_UP;
          if (wdog_expired) begin
            state_next = S_DONE;
            end_job    = 1'b1;
            end_status = ST_TIMEOUT;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      dir_q           <= 1'b0;
      target_q        <= '0;
      ctr_parallel_in <= '0;
      status          <= ST_OK;
      final_count     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        dir_q           <= cmd_dir;
        target_q        <= cmd_target;
        ctr_parallel_in <= cmd_start;
      end
      if (end_job) begin
        status      <= end_status;
        final_count <= ctr_count;
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: self-checking bench for counter_sequencer with a
// behavioural counter attached and a job-level reference model.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int N     = 16;
  localparam int WMAX  = 8;
`ifdef COUNTER_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_dir = 1'b0;
  logic [N-1:0] cmd_start = '0;
  logic [N-1:0] cmd_target = '0;
  logic         abort = 1'b0;
  logic [1:0]   ctr_control;
  logic [N-1:0] ctr_parallel_in;
  logic [N-1:0] ctr_count;
  logic         busy;
  logic         done;
  logic [1:0]   status;
  logic [N-1:0] final_count;

  counter_sequencer #(.N(N), .WDOG_MAX(WMAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dir         (cmd_dir),
    .cmd_start       (cmd_start),
    .cmd_target      (cmd_target),
    .abort           (abort),
    .ctr_control     (ctr_control),
    .ctr_parallel_in (ctr_parallel_in),
    .ctr_count       (ctr_count),
    .busy            (busy),
    .done            (done),
    .status          (status),
    .final_count     (final_count)
  );

  always #5 clk = ~clk;

  // Attached universal counter (no reset from the sequencer).
  logic [N-1:0] cnt = '0;
  assign ctr_count = cnt;
  always @(posedge clk) begin
    case (ctr_control)
      2'b11:   cnt <= ctr_parallel_in;
      2'b01:   cnt <= cnt + 1'b1;
      2'b10:   cnt <= cnt - 1'b1;
      default: cnt <= cnt;
    endcase
  end

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level reference model ----------------
  // A job is a sequence of cycles c = 0 (load), 1..term (run), term+1 (done).
  bit           m_active  = 1'b0;
  int           m_c       = 0;
  int           m_done_c  = 0;
  int           m_abort_c = -1;
  int           m_k       = 0;
  bit           m_dir     = 1'b0;
  logic [N-1:0] m_pin     = '0;
  logic [1:0]   m_status  = 2'b00;
  logic [N-1:0] m_final   = '0;
  logic [1:0]   m_st_n    = 2'b00;
  logic [N-1:0] m_fin_n   = '0;
  int           plan_abort = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_pin    = '0;
      m_status = 2'b00;
      m_final  = '0;
    end else if (m_active) begin
      if (m_c == m_done_c) begin
        m_active = 1'b0;
      end else begin
        m_c++;
        if (m_c == m_done_c) begin
          m_status = m_st_n;
          m_final  = m_fin_n;
        end
      end
    end else if (cmd_valid) begin
      logic [N-1:0] kk;
      int match_c, wdog_c, term;
      kk        = cmd_dir ? (cmd_start - cmd_target) : (cmd_target - cmd_start);
      m_k       = int'(kk);
      m_dir     = cmd_dir;
      m_pin     = cmd_start;
      m_abort_c = plan_abort;
      match_c   = m_k + 1;
      wdog_c    = WDOG_ON ? WMAX : 32'h4000_0000;
      if (plan_abort >= 0 && plan_abort <= match_c && plan_abort <= wdog_c) begin
        term = plan_abort; m_st_n = 2'b01;
      end else if (match_c <= wdog_c) begin
        term = match_c; m_st_n = 2'b00;
      end else begin
        term = wdog_c; m_st_n = 2'b10;
      end
      if (term == 0) m_fin_n = cnt;
      else if (cmd_dir) m_fin_n = cmd_start - N'(term - 1);
      else m_fin_n = cmd_start + N'(term - 1);
      m_done_c = term + 1;
      m_c      = 0;
      m_active = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] e_ctrl;
      bit e_done;
      e_done = m_active && (m_c == m_done_c);
      if (!m_active || e_done) e_ctrl = 2'b00;
      else if (m_c == 0) e_ctrl = 2'b11;
      else if (m_c == m_abort_c) e_ctrl = 2'b00;
      else if ((m_c - 1) == m_k) e_ctrl = 2'b00;
      else e_ctrl = m_dir ? 2'b10 : 2'b01;
      check("cmd_ready", 32'(cmd_ready), 32'(!m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(e_done));
      check("ctr_control", 32'(ctr_control), 32'(e_ctrl));
      check("ctr_parallel_in", 32'(ctr_parallel_in), 32'(m_pin));
      check("status", 32'(status), 32'(m_status));
      check("final_count", 32'(final_count), 32'(m_final));
    end
  end

  // ---------------- job driver ----------------
  logic [1:0] trace [0:15];
  int         done_at;

  task automatic run_job(input logic [N-1:0] s, input logic [N-1:0] t, input bit d,
                         input int ab, input bit noise);
    int guard;
    int c;
    int ntr;
    guard = 0;
    while (m_active && guard < 600) begin
      @(posedge clk); #1; guard++;
    end
    plan_abort = ab;
    cmd_start  = s;
    cmd_target = t;
    cmd_dir    = d;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (noise) begin
      cmd_start = N'($urandom); cmd_target = N'($urandom); cmd_dir = 1'($urandom);
    end
    c = 0; ntr = 0; done_at = -1;
    for (int i = 0; i < 16; i++) trace[i] = 2'bxx;
    while (m_active && c < 600) begin
      abort = (c == ab);
      if (noise && $urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd_start = N'($urandom); cmd_target = N'($urandom); cmd_dir = 1'($urandom);
      end
      #1;
      if (ntr < 16) begin trace[ntr] = ctr_control; ntr++; end
      if (done) done_at = c;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      c++;
    end
    abort = 1'b0;
    check("job_terminates", 32'(m_active), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_up [0:5];
    logic [1:0] exp_wr [0:4];
    exp_up = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    exp_wr = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};

    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_final", 32'(final_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Up job 5 -> 9
    run_job(16'd5, 16'd9, 1'b0, -1, 1'b0);
    for (int i = 0; i < 6; i++) check("up_trace", 32'(trace[i]), 32'(exp_up[i]));
    check("up_done_at", 32'(done_at), 32'd6);
    check("up_final", 32'(final_count), 32'd9);
    check("up_status", 32'(status), 32'(ST_OK));

    // Down job with wrap 0x0001 -> 0xFFFE
    run_job(16'h0001, 16'hFFFE, 1'b1, -1, 1'b0);
    for (int i = 0; i < 5; i++) check("wrap_trace", 32'(trace[i]), 32'(exp_wr[i]));
    check("wrap_done_at", 32'(done_at), 32'd5);
    check("wrap_final", 32'(final_count), 32'hFFFE);

    // start == target
    run_job(16'h1234, 16'h1234, 1'b0, -1, 1'b0);
    check("eq_trace0", 32'(trace[0]), 32'd3);
    check("eq_trace1", 32'(trace[1]), 32'd0);
    check("eq_done_at", 32'(done_at), 32'd2);
    check("eq_status", 32'(status), 32'(ST_OK));

    // Abort in the 10th RUN cycle of 0 -> 100
    run_job(16'd0, 16'd100, 1'b0, 10, 1'b0);
    if (WDOG_ON) begin
      check("abort_status", 32'(status), 32'(ST_TIMEOUT));
      check("abort_final", 32'(final_count), 32'd7);
      check("abort_done_at", 32'(done_at), 32'd9);
    end else begin
      check("abort_ctrl", 32'(trace[10]), 32'd0);
      check("abort_status", 32'(status), 32'(ST_ABORT));
      check("abort_final", 32'(final_count), 32'd9);
      check("abort_done_at", 32'(done_at), 32'd11);
    end

`ifdef COUNTER_SEQ_WDOG_EN
    run_job(16'd0, 16'd20, 1'b0, -1, 1'b0);
    check("wdog_status", 32'(status), 32'(ST_TIMEOUT));
    check("wdog_final", 32'(final_count), 32'd7);
    check("wdog_done_at", 32'(done_at), 32'd9);
`endif

    // Abort while loading
    run_job(16'h00AA, 16'h00B0, 1'b0, 0, 1'b0);
    check("ldabort_status", 32'(status), 32'(ST_ABORT));
    check("ldabort_done_at", 32'(done_at), 32'd1);

    // Reset in the middle of a 0 -> 50 job
    plan_abort = -1;
    cmd_start = 16'd0; cmd_target = 16'd50; cmd_dir = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ctrl", 32'(ctr_control), 32'd0);
    check("mid_rst_pin", 32'(ctr_parallel_in), 32'd0);
    check("mid_rst_status", 32'(status), 32'd0);
    check("mid_rst_final", 32'(final_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    run_job(16'd2, 16'd3, 1'b0, -1, 1'b0);
    check("post_rst_status", 32'(status), 32'(ST_OK));
    check("post_rst_final", 32'(final_count), 32'd3);

    // Randomized jobs with noise on the command port while busy
    for (int j = 0; j < 40; j++) begin
      logic [N-1:0] s, t;
      bit d;
      int delta, ab;
      d     = 1'($urandom);
      s     = N'($urandom);
      delta = $urandom_range(0, 40);
      t     = d ? (s - N'(delta)) : (s + N'(delta));
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, delta + 1)) : -1;
      run_job(s, t, d, ab, 1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller for the parametric N-bit universal synchronous counter. It accepts one count job at a time over a valid/ready handshake: start value, target value and direction. It drives the counter's control and parallel-load inputs to load the start value, then counts to the target, and reports completion with a status code and the final count. It sits between a host/test sequencer and the counter instance, replacing hand-written control vectors.

## Interface
- N, 16, counter width; must match the attached counter.
- WDOG_MAX, 1024, maximum RUN cycles before timeout; only used with the watchdog compiled in.
- WDOG_W, $clog2(WDOG_MAX+1), watchdog counter width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  sequencer idle, job accepted when valid&ready.
- cmd_dir  in  1  0 = count up, 1 = count down.
- cmd_start  in  N  value to parallel-load.
- cmd_target  in  N  value at which counting stops.
- abort  in  1  terminate current job.
- ctr_control  out  2  to counter: 00 hold, 01 up, 10 down, 11 load.
- ctr_parallel_in  out  N  to counter parallel_in.
- ctr_count  in  N  from counter count_out.
- busy  out  1  high in LOAD/RUN/DONE.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 reached, 01 aborted, 10 timeout; valid while done is high, held until next done.
- final_count  out  N  ctr_count captured on the transition into DONE; held.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1, ctr_control=00.
  - On cmd_valid, latch dir/start/target; ctr_parallel_in takes start; go to LOAD.
- LOAD: ctr_control=11. Go to RUN unless abort=1, in which case go to DONE with status 01.
- RUN:
  - ctr_control = 00 if ctr_count==target, else 01 (dir=0) or 10 (dir=1).
  - Transition priority:
    - abort → DONE, status 01.
    - Match → DONE, status 00.
    - Watchdog expiry → DONE, status 10.
    - Otherwise stay in RUN.
  - When abort is high, ctr_control is forced to 00 in that cycle.
- DONE: done=1, ctr_control=00, cmd_ready=0; next state IDLE unconditionally. cmd_valid in DONE is ignored.
- Arithmetic: the counter wraps modulo 2^N, so the target is always reached.
  - Step count k = (target−start) mod 2^N for up, (start−target) mod 2^N for down.
  - start==target gives k=0.
- The sequencer never resets the counter; the counter keeps its own reset.
- Reset values:
  - state IDLE, cmd_ready=1, busy=0, done=0.
  - status=00, final_count=0, ctr_control=00, ctr_parallel_in=0.
  - Latched cmd fields 0, watchdog 0.
- Reset asserted mid-job: immediate return to IDLE; no done pulse is produced for the lost job.

## Timing
- Edge E0 accepts the job; [E0,E1) is LOAD; the counter holds start after E1.
- During RUN cycle j (from E(1+j)), ctr_count = start ± j.
- The match is seen at j=k. DONE occupies [E(k+2), E(k+3)). cmd_ready is high again from E(k+3).
- Job latency: k+2 cycles to done. Minimum job-to-job spacing: k+3 cycles.
- All outputs are decoded from registered state and latched fields, except the RUN-state ctr_control. That output depends combinationally on ctr_count==target and abort.

## Configuration
- COUNTER_SEQ_WDOG_EN defined:
  - A watchdog counts RUN cycles and clears on entry to LOAD.
  - When it reaches WDOG_MAX without a match or abort, the job ends with status 10.
- Undefined: no watchdog logic; status 10 is never produced; WDOG_MAX and WDOG_W are unused.

## Structure
- Package counter_seq_pkg holds:
  - Control encodings: CTRL_HOLD, CTRL_UP, CTRL_DOWN, CTRL_LOAD.
  - State enum.
  - Status codes: ST_OK, ST_ABORT, ST_TIMEOUT.
- One sub-module, counter_seq_wdog: the watchdog counter with clear, enable and expired flag. It is instantiated only under COUNTER_SEQ_WDOG_EN.

## Test plan
- Up job, start=5, target=9 → ctr_control 11, 01×4, 00; done at E6; final_count=9; status 00.
- Down job with wrap, N=16, start=0x0001, target=0xFFFE → three 10 cycles; final_count=0xFFFE; done at E5.
- start=target=0x1234, dir=0 → LOAD, one RUN cycle with control 00; done at E2; status 00.
- Up job 0→100, abort pulsed in the 10th RUN cycle → control 00 in that cycle; done next cycle; status 01; final_count=9.
- With COUNTER_SEQ_WDOG_EN and WDOG_MAX=8, up job 0→20 → status 10 after 8 RUN cycles; final_count=7.
- rst asserted in RUN during job 0→50 → all outputs at reset values immediately; after release, cmd_ready=1 and a new job 2→3 completes with status 00.
